// File: rtl/pic_inta_sequencer.sv
// pic_inta_sequencer
// CPU-side interrupt acknowledge sequencer for an 8259A-style PIC. It
// synchronises INT, generates the active-low INTA pulse train (two pulses
// in 8086 mode, three in 8080/85 mode), samples the bytes the PIC drives
// on the data bus during each pulse, and hands the assembled result to the
// CPU core through a valid/ready handshake.

module pic_inta_sequencer #(
    parameter bit          MODE_8086       = 1'b1,
    parameter int unsigned INTA_LOW_CYCLES = 2,
    parameter int unsigned INTA_GAP_CYCLES = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        INT,
    input  logic        irq_enable,
    input  logic [7:0]  sys_DataLine,
    output logic        INTA,
    output logic        busy,
    output logic [15:0] vector,
    output logic        vector_valid,
    input  logic        vector_ready,
    output logic        opcode_err
);

    // Counter reload values: a phase of N cycles counts N-1 down to 0.
    localparam logic [3:0] LOW_RELOAD = 4'(INTA_LOW_CYCLES - 1);
    localparam logic [3:0] GAP_RELOAD = 4'(INTA_GAP_CYCLES - 1);

    // Index of the final pulse of the sequence.
    localparam logic [1:0] LAST_IDX = MODE_8086 ? 2'd1 : 2'd2;

    // CALL opcode the PIC must present first in 8080/85 mode.
    localparam logic [7:0] CALL_OPCODE = 8'hCD;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOW     = 2'd1,
        GAP     = 2'd2,
        PRESENT = 2'd3
    } state_t;

    // Synchroniser flops
    logic        int_meta_q;
    logic        int_s_q;

    // Sequencer state
    state_t      state_q, state_d;
    logic [1:0]  pulse_idx_q, pulse_idx_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  byte0_q, byte0_d;
    logic [7:0]  byte1_q, byte1_d;
    logic [7:0]  byte2_q, byte2_d;

    // Registered outputs
    logic [15:0] vector_q, vector_d;
    logic        vector_valid_q, vector_valid_d;
    logic        opcode_err_q, opcode_err_d;
    logic        inta_q, inta_d;
    logic        busy_q, busy_d;

    // Two-flop synchroniser bringing the asynchronous INT into the clk domain.
    always_ff @(posedge clk) begin
        if (reset) begin
            int_meta_q <= 1'b0;
            int_s_q    <= 1'b0;
        end else begin
            int_meta_q <= INT;
            int_s_q    <= int_meta_q;
        end
    end

    // Next-state, data capture and output computation for the INTA sequence.
    always_comb begin
        state_d        = state_q;
        pulse_idx_d    = pulse_idx_q;
        cnt_d          = cnt_q;
        byte0_d        = byte0_q;
        byte1_d        = byte1_q;
        byte2_d        = byte2_q;
        vector_d       = vector_q;
        vector_valid_d = vector_valid_q;
        opcode_err_d   = opcode_err_q;

        case (state_q)
            IDLE: begin
                if (int_s_q && irq_enable && !vector_valid_q) begin
                    state_d     = LOW;
                    pulse_idx_d = 2'd0;
                    cnt_d       = LOW_RELOAD;
                end
            end

            LOW: begin
                if (cnt_q == 4'd0) begin
                    case (pulse_idx_q)
                        2'd0:    byte0_d = sys_DataLine;
                        2'd1:    byte1_d = sys_DataLine;
                        default: byte2_d = sys_DataLine;
                    endcase

                    if (pulse_idx_q == LAST_IDX) begin
                        state_d        = PRESENT;
                        vector_valid_d = 1'b1;
                        if (MODE_8086) begin
                            vector_d     = {8'h00, byte1_d};
                            opcode_err_d = 1'b0;
                        end else begin
                            vector_d     = {byte2_d, byte1_d};
                            opcode_err_d = (byte0_d != CALL_OPCODE);
                        end
                    end else begin
                        state_d = GAP;
                        cnt_d   = GAP_RELOAD;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            GAP: begin
                if (cnt_q == 4'd0) begin
                    state_d     = LOW;
                    pulse_idx_d = pulse_idx_q + 2'd1;
                    cnt_d       = LOW_RELOAD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            PRESENT: begin
                if (vector_valid_q && vector_ready) begin
                    state_d        = IDLE;
                    vector_valid_d = 1'b0;
                    opcode_err_d   = 1'b0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // INTA and busy are registered from the next state so they change
        // cleanly on the same edge as the state transition.
        inta_d = (state_d != LOW);
        busy_d = (state_d == LOW) || (state_d == GAP);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            pulse_idx_q    <= 2'd0;
            cnt_q          <= 4'd0;
            byte0_q        <= 8'h00;
            byte1_q        <= 8'h00;
            byte2_q        <= 8'h00;
            vector_q       <= 16'h0000;
            vector_valid_q <= 1'b0;
            opcode_err_q   <= 1'b0;
            inta_q         <= 1'b1;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            pulse_idx_q    <= pulse_idx_d;
            cnt_q          <= cnt_d;
            byte0_q        <= byte0_d;
            byte1_q        <= byte1_d;
            byte2_q        <= byte2_d;
            vector_q       <= vector_d;
            vector_valid_q <= vector_valid_d;
            opcode_err_q   <= opcode_err_d;
            inta_q         <= inta_d;
            busy_q         <= busy_d;
        end
    end

    assign INTA         = inta_q;
    assign busy         = busy_q;
    assign vector       = vector_q;
    assign vector_valid = vector_valid_q;
    assign opcode_err   = opcode_err_q;

endmodule
